bcam_mgr: RTL and testbench

Command-side controller that owns a `bcam` instance's write and match ports. It accepts LOOKUP, INSERT and DELETE commands over a valid/ready handshake. It tracks per-entry validity and allocates free entries, guaranteeing at most one CAM entry per pattern. It returns one response per command, and sits between packet/flow logic and the CAM.

---
 rtl/bcam_mgr_pkg.sv | 32 +++
 rtl/bcam_mgr_penc.sv | 23 ++
 rtl/bcam_mgr.sv | 203 ++++++++++++++++++++
 tb/tb_bcam_mgr.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcam_mgr_pkg.sv
// Shared opcodes, response codes and FSM encoding for the bcam_mgr command controller.
package bcam_mgr_pkg;

    localparam logic [1:0] OP_LOOKUP = 2'd0;
    localparam logic [1:0] OP_INSERT = 2'd1;
    localparam logic [1:0] OP_DELETE = 2'd2;
    localparam logic [1:0] OP_RSVD   = 2'd3;

    typedef enum logic [1:0] {
        RSP_OK   = 2'd0,
        RSP_DUP  = 2'd1,
        RSP_MISS = 2'd2,
        RSP_FULL = 2'd3
    } rsp_code_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MWAIT  = 3'd1,
        ST_DECIDE = 3'd2,
        ST_WRITE  = 3'd3,
        ST_WWAIT  = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

    // One counter serves both the match and write waits, so size it for the longer one.
    function automatic int cnt_width(input int mlat, input int wlat);
        int mx;
        mx = (mlat > wlat) ? mlat : wlat;
        return (mx < 1) ? 1 : $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/bcam_mgr_penc.sv
// Lowest-index-zero priority encoder over the entry valid bitmap; purely combinational.
module bcam_mgr_penc #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] valid,
    output logic [AW-1:0]    freeAddr,
    output logic             anyFree
);

    // Scan high to low so the last (lowest) free index wins.
    always_comb begin
        freeAddr = '0;
        anyFree  = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                freeAddr = AW'(i);
                anyFree  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcam_mgr.sv
// Command-side controller for a bcam: LOOKUP/INSERT/DELETE with entry allocation and uniqueness.
// Optional occupancy counter and occ/full ports are enabled by defining BCAM_MGR_OCC_EN.
module bcam_mgr
    import bcam_mgr_pkg::*;
#(
    parameter int CAMD = 256,
    parameter int CAMW = 32,
    parameter int MLAT = 2,
    parameter int WLAT = 2,
    localparam int ADDRW = $clog2(CAMD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmdVld,
    output logic             cmdRdy,
    input  logic [1:0]       cmdOp,
    input  logic [CAMW-1:0]  cmdPatt,
    output logic             rspVld,
    output logic [1:0]       rspCode,
    output logic [ADDRW-1:0] rspAddr,
    output logic             camWEnb,
    output logic [ADDRW-1:0] camWAddr,
    output logic [CAMW-1:0]  camWPatt,
    output logic [CAMW-1:0]  camMPatt,
`ifdef BCAM_MGR_OCC_EN
    output logic [ADDRW:0]   occ,
    output logic             full,
`endif
    input  logic             camMatch,
    input  logic [ADDRW-1:0] camMAddr
);

    localparam int CNTW = cnt_width(MLAT, WLAT);

    state_e           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [CAMD-1:0]  valid_q, valid_d;
    logic [1:0]       op_q, op_d;
    logic [CAMW-1:0]  mpatt_q, mpatt_d;
    rsp_code_e        rsp_code_q, rsp_code_d;
    logic [ADDRW-1:0] rsp_addr_q, rsp_addr_d;
    logic [ADDRW-1:0] waddr_q, waddr_d;
    logic [CAMW-1:0]  wpatt_q, wpatt_d;

    logic [ADDRW-1:0] free_addr;
    logic             any_free;
    logic             qual_hit;
    logic             stale_hit;
    logic             full_dec;

    bcam_mgr_penc #(
        .DEPTH (CAMD),
        .AW    (ADDRW)
    ) u_penc (
        .valid    (valid_q),
        .freeAddr (free_addr),
        .anyFree  (any_free)
    );

    // A CAM hit only counts if the manager still considers that entry live.
    assign qual_hit  = camMatch &  valid_q[camMAddr];
    assign stale_hit = camMatch & ~valid_q[camMAddr];

`ifdef BCAM_MGR_OCC_EN
    logic [ADDRW:0] occ_q, occ_d;

    assign full     = (occ_q == (ADDRW+1)'(CAMD));
    assign occ      = occ_q;
    assign full_dec = full;

    always_comb begin
        occ_d = occ_q;
        if (state_q == ST_DECIDE) begin
            if (op_q == OP_INSERT && !qual_hit && (stale_hit || (!full_dec && any_free)))
                occ_d = occ_q + (ADDRW+1)'(1);
            else if (op_q == OP_DELETE && qual_hit)
                occ_d = occ_q - (ADDRW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) occ_q <= '0;
        else      occ_q <= occ_d;
    end
`else
    assign full_dec = &valid_q;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        op_d       = op_q;
        mpatt_d    = mpatt_q;
        rsp_code_d = rsp_code_q;
        rsp_addr_d = rsp_addr_q;
        waddr_d    = waddr_q;
        wpatt_d    = wpatt_q;

        case (state_q)
            ST_IDLE: begin
                if (cmdVld) begin
                    op_d    = cmdOp;
                    mpatt_d = cmdPatt;
                    cnt_d   = '0;
                    state_d = ST_MWAIT;
                end
            end
            ST_MWAIT: begin
                if (cnt_q == CNTW'(MLAT - 1)) state_d = ST_DECIDE;
                else                          cnt_d   = cnt_q + CNTW'(1);
            end
            ST_DECIDE: begin
                state_d    = ST_RESP;
                rsp_code_d = RSP_MISS;
                rsp_addr_d = '0;
                case (op_q)
                    OP_INSERT: begin
                        if (qual_hit) begin
                            rsp_code_d = RSP_DUP;
                            rsp_addr_d = camMAddr;
                        end else if (stale_hit) begin
                            // Pattern still sits in the CAM: revive it rather than write a duplicate.
                            valid_d[camMAddr] = 1'b1;
                            rsp_code_d        = RSP_OK;
                            rsp_addr_d        = camMAddr;
                        end else if (full_dec || !any_free) begin
                            rsp_code_d = RSP_FULL;
                        end else begin
                            valid_d[free_addr] = 1'b1;
                            rsp_code_d         = RSP_OK;
                            rsp_addr_d         = free_addr;
                            waddr_d            = free_addr;
                            wpatt_d            = mpatt_q;
                            cnt_d              = '0;
                            state_d            = ST_WRITE;
                        end
                    end
                    OP_DELETE: begin
                        if (qual_hit) begin
                            valid_d[camMAddr] = 1'b0;
                            rsp_code_d        = RSP_OK;
                            rsp_addr_d        = camMAddr;
                        end
                    end
                    default: begin
                        if (qual_hit) begin
                            rsp_code_d = RSP_OK;
                            rsp_addr_d = camMAddr;
                        end
                    end
                endcase
            end
            ST_WRITE: begin
                state_d = ST_WWAIT;
            end
            ST_WWAIT: begin
                if (cnt_q == CNTW'(WLAT - 1)) state_d = ST_RESP;
                else                          cnt_d   = cnt_q + CNTW'(1);
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            valid_q    <= '0;
            op_q       <= OP_LOOKUP;
            mpatt_q    <= '0;
            rsp_code_q <= RSP_OK;
            rsp_addr_q <= '0;
            waddr_q    <= '0;
            wpatt_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            op_q       <= op_d;
            mpatt_q    <= mpatt_d;
            rsp_code_q <= rsp_code_d;
            rsp_addr_q <= rsp_addr_d;
            waddr_q    <= waddr_d;
            wpatt_q    <= wpatt_d;
        end
    end

    assign cmdRdy   = (state_q == ST_IDLE);
    assign rspVld   = (state_q == ST_RESP);
    assign camWEnb  = (state_q == ST_WRITE);
    assign rspCode  = rsp_code_q;
    assign rspAddr  = rsp_addr_q;
    assign camWAddr = waddr_q;
    assign camWPatt = wpatt_q;
    assign camMPatt = mpatt_q;

endmodule

// File: tb/tb_bcam_mgr.sv
// Directed bench for bcam_mgr with a behavioural CAM model (MLAT-deep match pipe, WLAT write delay).
module tb_bcam_mgr;

    localparam int CAMD  = 8;
    localparam int CAMW  = 32;
    localparam int MLAT  = 2;
    localparam int WLAT  = 2;
    localparam int ADDRW = 3;

    localparam logic [1:0] OP_L = 2'd0, OP_I = 2'd1, OP_D = 2'd2;
    localparam logic [1:0] C_OK = 2'd0, C_DUP = 2'd1, C_MISS = 2'd2, C_FULL = 2'd3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmdVld = 1'b0;
    logic             cmdRdy;
    logic [1:0]       cmdOp = 2'd0;
    logic [CAMW-1:0]  cmdPatt = '0;
    logic             rspVld;
    logic [1:0]       rspCode;
    logic [ADDRW-1:0] rspAddr;
    logic             camWEnb;
    logic [ADDRW-1:0] camWAddr;
    logic [CAMW-1:0]  camWPatt;
    logic [CAMW-1:0]  camMPatt;
    logic             camMatch;
    logic [ADDRW-1:0] camMAddr;
`ifdef BCAM_MGR_OCC_EN
    logic [ADDRW:0]   occ;
    logic             full;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wr_cnt   = 0;
    int rsp_cnt  = 0;
    int wr_cyc   = 0;
    logic [ADDRW-1:0] wr_addr = '0;
    logic [CAMW-1:0]  wr_patt = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcam_mgr #(.CAMD(CAMD), .CAMW(CAMW), .MLAT(MLAT), .WLAT(WLAT)) dut (
        .clk(clk), .rst(rst), .cmdVld(cmdVld), .cmdRdy(cmdRdy), .cmdOp(cmdOp), .cmdPatt(cmdPatt),
        .rspVld(rspVld), .rspCode(rspCode), .rspAddr(rspAddr),
        .camWEnb(camWEnb), .camWAddr(camWAddr), .camWPatt(camWPatt), .camMPatt(camMPatt),
`ifdef BCAM_MGR_OCC_EN
        .occ(occ), .full(full),
`endif
        .camMatch(camMatch), .camMAddr(camMAddr)
    );

    // Behavioural CAM: contents survive reset, lowest matching index wins.
    logic [CAMW-1:0]  cam_mem [CAMD];
    logic [CAMD-1:0]  cam_wr = '0;
    logic             srch_hit;
    logic [ADDRW-1:0] srch_addr;
    logic [MLAT-1:0]  mp_hit = '0;
    logic [ADDRW-1:0] mp_addr [MLAT];
    logic [WLAT-1:0]  wp_en = '0;
    logic [ADDRW-1:0] wp_addr [WLAT];
    logic [CAMW-1:0]  wp_patt [WLAT];

    always_comb begin
        srch_hit  = 1'b0;
        srch_addr = '0;
        for (int i = CAMD - 1; i >= 0; i--) begin
            if (cam_wr[i] && cam_mem[i] == camMPatt) begin
                srch_hit  = 1'b1;
                srch_addr = ADDRW'(i);
            end
        end
    end

    always @(posedge clk) begin
        mp_hit[0]  <= srch_hit;
        mp_addr[0] <= srch_addr;
        for (int i = 1; i < MLAT; i++) begin
            mp_hit[i]  <= mp_hit[i-1];
            mp_addr[i] <= mp_addr[i-1];
        end
        wp_en[0]   <= camWEnb;
        wp_addr[0] <= camWAddr;
        wp_patt[0] <= camWPatt;
        for (int i = 1; i < WLAT; i++) begin
            wp_en[i]   <= wp_en[i-1];
            wp_addr[i] <= wp_addr[i-1];
            wp_patt[i] <= wp_patt[i-1];
        end
        if (wp_en[WLAT-1]) begin
            cam_mem[wp_addr[WLAT-1]] <= wp_patt[WLAT-1];
            cam_wr[wp_addr[WLAT-1]]  <= 1'b1;
        end
    end

    assign camMatch = mp_hit[MLAT-1];
    assign camMAddr = mp_addr[MLAT-1];

    always @(negedge clk) begin
        if (camWEnb) begin
            wr_cnt  <= wr_cnt + 1;
            wr_cyc  <= cyc;
            wr_addr <= camWAddr;
            wr_patt <= camWPatt;
        end
        if (rspVld) rsp_cnt <= rsp_cnt + 1;
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b0; cmdVld = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // One command: checks latency, code, address, response count and write side effects.
    task automatic do_cmd(input string nm, input logic [1:0] op, input logic [CAMW-1:0] patt,
                          input logic [1:0] ecode, input logic [ADDRW-1:0] eaddr, input int ewr);
        int t, wr0, rsp0, lat, elat;
        bit got;
        @(posedge clk); #1;
        cmdVld = 1'b1; cmdOp = op; cmdPatt = patt;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (cmdRdy) got = 1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s accept: cmdRdy=0 required 1", nm);
        end
        t = cyc; wr0 = wr_cnt; rsp0 = rsp_cnt;
        @(posedge clk); #1 cmdVld = 1'b0;
        @(negedge clk);
        n_checks++;
        if (camMPatt !== patt) begin
            n_fail++;
            $display("FAIL %s camMPatt: got %h required %h", nm, camMPatt, patt);
        end
        got = 0; lat = -1;
        for (int i = 0; i < 60 && !got; i++) begin
            if (rspVld) begin got = 1; lat = cyc - t; end
            else @(negedge clk);
        end
        elat = (ewr != 0) ? MLAT + WLAT + 3 : MLAT + 2;
        n_checks++;
        if (lat !== elat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d required %0d", nm, lat, elat);
        end
        n_checks++;
        if (rspCode !== ecode) begin
            n_fail++;
            $display("FAIL %s rspCode: got %0d required %0d", nm, rspCode, ecode);
        end
        n_checks++;
        if (rspAddr !== eaddr) begin
            n_fail++;
            $display("FAIL %s rspAddr: got %0d required %0d", nm, rspAddr, eaddr);
        end
        @(negedge clk);
        n_checks++;
        if (rsp_cnt - rsp0 !== 1) begin
            n_fail++;
            $display("FAIL %s rsp count: got %0d required 1", nm, rsp_cnt - rsp0);
        end
        n_checks++;
        if (wr_cnt - wr0 !== ewr) begin
            n_fail++;
            $display("FAIL %s write count: got %0d required %0d", nm, wr_cnt - wr0, ewr);
        end
        if (ewr != 0) begin
            n_checks++;
            if (wr_addr !== eaddr || wr_patt !== patt || wr_cyc - t !== MLAT + 2) begin
                n_fail++;
                $display("FAIL %s write: got addr %0d patt %h at +%0d required addr %0d patt %h at +%0d",
                         nm, wr_addr, wr_patt, wr_cyc - t, eaddr, patt, MLAT + 2);
            end
        end
        $display("cmd %-14s op=%0d patt=%h -> code=%0d addr=%0d lat=%0d", nm, op, patt, rspCode, rspAddr, lat);
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_checks++;
        if (cmdRdy !== 1'b1 || rspVld !== 1'b0 || camWEnb !== 1'b0) begin
            n_fail++;
            $display("FAIL reset handshake: got rdy=%b rsp=%b wen=%b required 1 0 0", cmdRdy, rspVld, camWEnb);
        end
        n_checks++;
        if (rspCode !== 2'd0 || rspAddr !== '0 || camWAddr !== '0 || camWPatt !== '0 || camMPatt !== '0) begin
            n_fail++;
            $display("FAIL reset regs: got code=%0d addr=%0d waddr=%0d wpatt=%h mpatt=%h required all 0",
                     rspCode, rspAddr, camWAddr, camWPatt, camMPatt);
        end
        $display("reset: rdy=%b rspVld=%b camWEnb=%b", cmdRdy, rspVld, camWEnb);
    endtask

    task automatic test_basic();
        do_cmd("lookup_dead", OP_L, 32'hDEADBEEF, C_MISS, 3'd0, 0);
        do_cmd("insert_a5",   OP_I, 32'hA5A5A5A5, C_OK,   3'd0, 1);
        do_cmd("lookup_a5",   OP_L, 32'hA5A5A5A5, C_OK,   3'd0, 0);
        do_cmd("insert_dup",  OP_I, 32'hA5A5A5A5, C_DUP,  3'd0, 0);
        do_cmd("delete_a5",   OP_D, 32'hA5A5A5A5, C_OK,   3'd0, 0);
        do_cmd("lookup_gone", OP_L, 32'hA5A5A5A5, C_MISS, 3'd0, 0);
        do_cmd("rsvd_gone",   2'd3, 32'hA5A5A5A5, C_MISS, 3'd0, 0);
        do_cmd("delete_miss", OP_D, 32'h12345678, C_MISS, 3'd0, 0);
        do_cmd("insert_stale", OP_I, 32'hA5A5A5A5, C_OK,  3'd0, 0);
        do_cmd("rsvd_live",   2'd3, 32'hA5A5A5A5, C_OK,   3'd0, 0);
    endtask

    task automatic test_fill();
        apply_reset();
        for (int i = 1; i <= CAMD; i++)
            do_cmd($sformatf("fill_%0d", i), OP_I, CAMW'(i), C_OK, ADDRW'(i - 1), 1);
`ifdef BCAM_MGR_OCC_EN
        n_checks++;
        if (full !== 1'b1 || occ !== 4'd8) begin
            n_fail++;
            $display("FAIL occ_full: got occ=%0d full=%b required 8 1", occ, full);
        end
`endif
        do_cmd("insert_full", OP_I, 32'd9, C_FULL, 3'd0, 0);
        do_cmd("delete_4",    OP_D, 32'd4, C_OK,   3'd3, 0);
`ifdef BCAM_MGR_OCC_EN
        n_checks++;
        if (full !== 1'b0 || occ !== 4'd7) begin
            n_fail++;
            $display("FAIL occ_after_del: got occ=%0d full=%b required 7 0", occ, full);
        end
`endif
        do_cmd("insert_9",    OP_I, 32'd9, C_OK,   3'd3, 1);
        do_cmd("lookup_9",    OP_L, 32'd9, C_OK,   3'd3, 0);
        do_cmd("lookup_8",    OP_L, 32'd8, C_OK,   3'd7, 0);
    endtask

    task automatic test_back_to_back();
        int accepts, rsps;
        bit busy, prev_rsp;
        logic [1:0]       codes [2];
        logic [ADDRW-1:0] addrs [2];
        apply_reset();
        accepts = 0; rsps = 0; busy = 0; prev_rsp = 0;
        @(posedge clk); #1;
        cmdVld = 1'b1; cmdOp = OP_I; cmdPatt = 32'h77;
        for (int i = 0; i < 80 && rsps < 2; i++) begin
            @(negedge clk);
            if (prev_rsp) begin
                n_checks++;
                if (cmdRdy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b rdy_after_rsp: got %b required 1", cmdRdy);
                end
            end
            prev_rsp = 0;
            if (busy && cmdRdy) begin
                n_checks++; n_fail++;
                $display("FAIL b2b rdy_while_busy: got 1 required 0");
            end
            if (cmdRdy && cmdVld) begin accepts++; busy = 1; end
            if (rspVld) begin
                codes[rsps] = rspCode; addrs[rsps] = rspAddr;
                $display("b2b rsp %0d: code=%0d addr=%0d", rsps, rspCode, rspAddr);
                rsps++; busy = 0; prev_rsp = 1;
                if (rsps == 1) begin cmdOp = OP_L; cmdPatt = 32'h77; end
                else cmdVld = 1'b0;
            end
        end
        cmdVld = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (rsps !== 2 || accepts !== 2) begin
            n_fail++;
            $display("FAIL b2b counts: got rsps=%0d accepts=%0d required 2 2", rsps, accepts);
        end
        n_checks++;
        if (codes[0] !== C_OK || addrs[0] !== 3'd0 || codes[1] !== C_OK || addrs[1] !== 3'd0) begin
            n_fail++;
            $display("FAIL b2b results: got %0d/%0d %0d/%0d required 0/0 0/0", codes[0], addrs[0], codes[1], addrs[1]);
        end
    endtask

    task automatic test_reset_mid_write();
        int rsp0;
        bit got;
        @(posedge clk); #1;
        cmdVld = 1'b1; cmdOp = OP_I; cmdPatt = 32'hCAFE;
        @(posedge clk); #1 cmdVld = 1'b0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (camWEnb) got = 1;
        end
        n_checks++;
        if (!got || camWAddr !== 3'd1) begin
            n_fail++;
            $display("FAIL rstw write: got wen=%b addr=%0d required 1 1", got, camWAddr);
        end
        rsp0 = rsp_cnt;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (cmdRdy !== 1'b1 || rspVld !== 1'b0 || camWEnb !== 1'b0 || camWAddr !== '0) begin
            n_fail++;
            $display("FAIL rstw idle: got rdy=%b rsp=%b wen=%b waddr=%0d required 1 0 0 0",
                     cmdRdy, rspVld, camWEnb, camWAddr);
        end
        @(posedge clk); #1 rst = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (rsp_cnt !== rsp0) begin
            n_fail++;
            $display("FAIL rstw no_rsp: got %0d responses required 0", rsp_cnt - rsp0);
        end
        $display("reset mid-write: rdy=%b responses=%0d", cmdRdy, rsp_cnt - rsp0);
        do_cmd("lookup_cafe", OP_L, 32'hCAFE, C_MISS, 3'd0, 0);
        do_cmd("lookup_77",   OP_L, 32'h77,   C_MISS, 3'd0, 0);
        do_cmd("insert_cafe", OP_I, 32'hCAFE, C_OK,   3'd1, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_back_to_back();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
